// File: rtl/rx_uart_if.sv
// ---------------------------------------------------------------------------
// rx_uart_if
//   Bundles the serial line and the parallel receive-side outputs of the UART
//   receiver so they can be passed around as a single port.
//
//   Signals
//     rx         serial input, idle high (driven by the line / testbench)
//     rx_data    last good received word, BIT_MAX bits wide
//     rx_valid   one-cycle pulse, rx_data was updated this cycle
//     frame_err  one-cycle pulse, stop bit was low and the frame was dropped
//     rx_busy    high while the receiver is inside a frame
//
//   Modports
//     master     the receiver itself: consumes rx, produces the outputs
//     slave      whoever drives the line and consumes the received data
// ---------------------------------------------------------------------------
interface rx_uart_if #(
   parameter int BIT_MAX = 8
);

   logic               rx;
   logic [BIT_MAX-1:0] rx_data;
   logic               rx_valid;
   logic               frame_err;
   logic               rx_busy;

   modport master (
      input  rx,
      output rx_data,
      output rx_valid,
      output frame_err,
      output rx_busy
   );

   modport slave (
      output rx,
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  rx_busy
   );

endinterface

// File: rtl/rx_uart.sv
// ---------------------------------------------------------------------------
// rx_uart
//   UART receiver for frames of one low start bit, BIT_MAX data bits sent
//   LSB first, and one high stop bit. Every bit lasts BPS_MAX clock cycles,
//   matching the transmitter on the other end of the link. The asynchronous
//   rx pin is synchronised, a start is detected on a falling edge, and each
//   bit is then sampled near its centre.
//
//   Parameters
//     BPS_MAX   clock cycles per bit, must be >= 4
//     BIT_MAX   data bits per frame, 1..8 (must match the interface width)
//
//   Ports
//     clk       system clock, everything on the rising edge
//     rst       synchronous active-high reset
//     bus       rx_uart_if master modport:
//                 rx        asynchronous serial input, idle high
//                 rx_data   last good word, held until the next good frame
//                 rx_valid  one-cycle pulse when rx_data is updated
//                 frame_err one-cycle pulse when the stop bit is low
//                 rx_busy   high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module rx_uart #(
   parameter int BPS_MAX = 5208,
   parameter int BIT_MAX = 8
) (
   input  logic          clk,
   input  logic          rst,
   rx_uart_if.master     bus
);

   localparam int HALF  = BPS_MAX / 2;
   localparam int CNT_W = $clog2(BPS_MAX);
   localparam int BIT_W = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

   localparam logic [CNT_W-1:0] BPS_LAST  = CNT_W'(BPS_MAX - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_MAX - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t               state_q,    state_d;
   logic [CNT_W-1:0]     bps_cnt_q,  bps_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [BIT_MAX-1:0]   shift_q,    shift_d;
   logic [BIT_MAX-1:0]   rx_data_q,  rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;

   // Synchroniser chain: rx_meta and rx_s are the two metastability flops,
   // rx_d is one more stage used only to spot the falling edge.
   logic                 rx_meta_q, rx_meta_d;
   logic                 rx_s_q,    rx_s_d;
   logic                 rx_d_q,    rx_d_d;
   logic                 fall;

   // The synchroniser just shifts the pin along one stage per clock.
   always_comb begin
      rx_meta_d = bus.rx;
      rx_s_d    = rx_meta_q;
      rx_d_d    = rx_s_q;
   end

   // Falling edge of the synchronised line: it was high one cycle ago and is
   // low now. A line that is held low (break) never produces a second edge.
   assign fall = rx_d_q & ~rx_s_q;

   // Next-state logic for the frame FSM, the bit-period counter, the data
   // bit index and the output pulses. The START state only waits half a bit
   // so that every later sample, spaced a full bit apart, lands mid-bit.
   always_comb begin
      state_d     = state_q;
      bps_cnt_d   = bps_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            bps_cnt_d = '0;
            bit_cnt_d = '0;
            if (fall) begin
               state_d = START;
            end
         end

         START: begin
            if (bps_cnt_q == HALF_LAST) begin
               bps_cnt_d = '0;
               bit_cnt_d = '0;
               // A line that is high again at mid start bit was only a glitch.
               if (rx_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
               end
            end else begin
               bps_cnt_d = bps_cnt_q + CNT_W'(1);
            end
         end

         DATA: begin
            if (bps_cnt_q == BPS_LAST) begin
               bps_cnt_d          = '0;
               shift_d[bit_cnt_q] = rx_s_q;
               if (bit_cnt_q == BIT_LAST) begin
                  state_d = STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else begin
               bps_cnt_d = bps_cnt_q + CNT_W'(1);
            end
         end

         STOP: begin
            // The stop sample sits mid stop bit, leaving half a bit of slack
            // to get back to IDLE before a back-to-back start edge arrives.
            if (bps_cnt_q == BPS_LAST) begin
               bps_cnt_d = '0;
               state_d   = IDLE;
               if (rx_s_q) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               bps_cnt_d = bps_cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            bps_cnt_d = '0;
            bit_cnt_d = '0;
         end
      endcase
   end

   // State register. Reset aborts any frame in flight without a pulse and
   // presets the synchroniser to the idle-high line level so that reset
   // itself can never look like a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bps_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_d_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         bps_cnt_q   <= bps_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
         rx_d_q      <= rx_d_d;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.rx_busy   = (state_q != IDLE);

   // A frame ends either good or bad, never both.
   a_pulse_exclusive : assert property (@(posedge clk) disable iff (rst)
      !(rx_valid_q && frame_err_q));

   // The bit-period counter never leaves its 0..BPS_MAX-1 range.
   a_cnt_range : assert property (@(posedge clk) disable iff (rst)
      bps_cnt_q <= BPS_LAST);

endmodule

// File: tb/tb_rx_uart.sv
// ---------------------------------------------------------------------------
// tb_rx_uart
//   Drives whole UART frames onto the line and compares what the receiver
//   reports against a simple frame-level model: a frame with a high stop bit
//   yields its data byte, a frame with a low stop bit yields an error and
//   leaves the last good byte in place.
// ---------------------------------------------------------------------------
module tb_rx_uart;

   localparam int BPS   = 16;
   localparam int BITS  = 8;
   localparam int HALF  = BPS / 2;
   localparam int LAT   = 3 + HALF + (BITS + 1) * BPS;
   localparam int FRAME = (BITS + 2) * BPS;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rx_uart_if #(.BIT_MAX(BITS)) bus ();

   rx_uart #(
      .BPS_MAX (BPS),
      .BIT_MAX (BITS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // One entry per receiver pulse seen on the outputs.
   typedef struct {
      logic       isErr;
      logic [7:0] data;
      int         cyc;
   } event_t;

   // One table vector: a frame to send and what should come out of it.
   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      int         gapBits;
      logic       expErr;
      logic [7:0] expData;
   } vec_t;

   event_t     evQ[$];
   int         cycP       = 0;
   int         vecCount   = 0;
   int         missCount  = 0;
   int         fallCyc    = 0;
   int         prevGap    = -1;
   int         prevEvCyc  = 0;
   logic [7:0] lastGood   = 8'h00;
   vec_t       vecs[8];

   // Free-running cycle count, read only on falling edges.
   always @(posedge clk) cycP <= cycP + 1;

   // Record every output pulse; a simultaneous valid and error is a failure.
   always @(negedge clk) begin
      if (bus.rx_valid || bus.frame_err) begin
         evQ.push_back('{isErr: bus.frame_err, data: bus.rx_data, cyc: cycP});
         vecCount++;
         if (bus.rx_valid && bus.frame_err) begin
            missCount++;
            $display("[TB] FAIL pulse_overlap: got valid=1 err=1, expected at most one high");
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vecCount++;
      if (actual != expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkRange(input string name, input int actual, input int lo, input int hi);
      vecCount++;
      if (actual < lo || actual > hi) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic driveBits(input logic v, input int n);
      bus.rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic sendFrame(input logic [7:0] d, input logic stopBit);
      bus.rx  = 1'b0;
      fallCyc = cycP;
      repeat (BPS) @(negedge clk);
      for (int i = 0; i < BITS; i++) driveBits(d[i], BPS);
      driveBits(stopBit, BPS);
   endtask

   // Send one frame, then check the single expected pulse, its latency, the
   // held data word, that the receiver is idle, and (when the frame followed
   // the previous one with no gap) the spacing between pulses.
   task automatic applyStimulus(input string name, input logic [7:0] d, input logic stopBit,
                                input int gapBits, input logic expErr, input logic [7:0] expData);
      int     startIdx;
      event_t ev;
      startIdx = evQ.size();
      sendFrame(d, stopBit);
      checkOutput({name, " pulses"}, evQ.size() - startIdx, 1);
      if (evQ.size() > startIdx) begin
         ev = evQ[startIdx];
         checkOutput({name, " is_err"}, int'(ev.isErr), int'(expErr));
         checkRange({name, " latency"}, ev.cyc - fallCyc, LAT - 1, LAT + 1);
         if (prevGap == 0) checkRange({name, " spacing"}, ev.cyc - prevEvCyc, FRAME - 1, FRAME + 1);
         prevEvCyc = ev.cyc;
         prevGap   = gapBits;
      end else begin
         prevGap = -1;
      end
      checkOutput({name, " rx_data"}, int'(bus.rx_data), int'(expData));
      checkOutput({name, " rx_busy"}, int'(bus.rx_busy), 0);
      driveBits(1'b1, gapBits * BPS);
   endtask

   initial begin
      int         startIdx;
      logic [7:0] d;
      logic       stopBit;
      int         gap;

      vecs[0] = '{8'h55, 1'b1, 2, 1'b0, 8'h55};
      vecs[1] = '{8'hA3, 1'b1, 0, 1'b0, 8'hA3};
      vecs[2] = '{8'h00, 1'b1, 2, 1'b0, 8'h00};
      vecs[3] = '{8'h55, 1'b1, 1, 1'b0, 8'h55};
      vecs[4] = '{8'h3C, 1'b0, 2, 1'b1, 8'h55};
      vecs[5] = '{8'hFF, 1'b1, 0, 1'b0, 8'hFF};
      vecs[6] = '{8'h80, 1'b1, 0, 1'b0, 8'h80};
      vecs[7] = '{8'h01, 1'b0, 1, 1'b1, 8'h80};

      // Reset state.
      bus.rx = 1'b1;
      rst    = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset rx_data",   int'(bus.rx_data),   0);
      checkOutput("reset rx_valid",  int'(bus.rx_valid),  0);
      checkOutput("reset frame_err", int'(bus.frame_err), 0);
      checkOutput("reset rx_busy",   int'(bus.rx_busy),   0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Table vectors: good frames, back-to-back frames, bad stop bits.
      for (int i = 0; i < 8; i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].data, vecs[i].stopBit,
                       vecs[i].gapBits, vecs[i].expErr, vecs[i].expData);
      end
      lastGood = 8'h80;

      // Short low glitch: busy briefly, then idle again with no pulse.
      prevGap  = -1;
      startIdx = evQ.size();
      bus.rx   = 1'b0;
      repeat (4) @(negedge clk);
      bus.rx   = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("glitch busy_early", int'(bus.rx_busy), 1);
      repeat (HALF - 1) @(negedge clk);
      checkOutput("glitch busy_late", int'(bus.rx_busy), 0);
      repeat (3 * BPS) @(negedge clk);
      checkOutput("glitch pulses", evQ.size() - startIdx, 0);
      checkOutput("glitch rx_data", int'(bus.rx_data), int'(lastGood));

      // Break: line low for three frame times gives exactly one error.
      startIdx = evQ.size();
      driveBits(1'b0, 3 * FRAME);
      checkOutput("break pulses", evQ.size() - startIdx, 1);
      if (evQ.size() > startIdx) checkOutput("break is_err", int'(evQ[startIdx].isErr), 1);
      checkOutput("break rx_busy", int'(bus.rx_busy), 0);
      driveBits(1'b1, 4 * BPS);
      checkOutput("break release pulses", evQ.size() - startIdx, 1);
      checkOutput("break release busy", int'(bus.rx_busy), 0);
      checkOutput("break rx_data", int'(bus.rx_data), int'(lastGood));

      // Reset in the middle of data bit 4 of 0xF0, then a clean 0x81.
      startIdx = evQ.size();
      d        = 8'hF0;
      driveBits(1'b0, BPS);
      for (int i = 0; i < 4; i++) driveBits(d[i], BPS);
      driveBits(d[4], HALF);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midreset rx_data",   int'(bus.rx_data),   0);
      checkOutput("midreset rx_valid",  int'(bus.rx_valid),  0);
      checkOutput("midreset frame_err", int'(bus.frame_err), 0);
      checkOutput("midreset rx_busy",   int'(bus.rx_busy),   0);
      driveBits(d[4], HALF - 1);
      for (int i = 5; i < 8; i++) driveBits(d[i], BPS);
      driveBits(1'b1, 3 * BPS);
      checkOutput("midreset pulses", evQ.size() - startIdx, 0);
      applyStimulus("after_reset", 8'h81, 1'b1, 1, 1'b0, 8'h81);
      lastGood = 8'h81;

      // Random frames against the frame-level model.
      for (int i = 0; i < 24; i++) begin
         d       = 8'($urandom_range(0, 255));
         stopBit = ($urandom_range(0, 5) != 0);
         gap     = stopBit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
         if (stopBit) lastGood = d;
         applyStimulus($sformatf("rand%0d", i), d, stopBit, gap, !stopBit, lastGood);
      end

      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
